score_lives: RTL and testbench
==============================

# score_lives

Game bookkeeping stage directly downstream of the asteroid ball instances. It collects the per-asteroid `inc_score` and `dec_lives` pulses, keeps a saturating BCD score and a lives counter, and runs the game state machine (idle, play, hit-freeze, over). It also gates the shared `move` tick back to the asteroids, so that motion stops outside active play.

## Interface

Parameters:
- `NUM_AST`, 4: number of asteroid instances. Legal range 1..7.
- `START_LIVES`, 3: lives loaded on game start. Legal range 1..7.
- `HIT_FRAMES`, 60: number of `frame` ticks the freeze lasts after a life is lost. Legal range 1..255.

Ports:
- `clk`, in, 1: 100 MHz system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `pixpulse`, in, 1: pixel-rate enable, high one cycle in four.
- `frame`, in, 1: one-cycle pulse per video frame. Only sampled when `pixpulse` is high.
- `move_in`, in, 1: raw motion tick from the timing generator.
- `inc_score`, in, `NUM_AST`: per-asteroid score events, one bit per asteroid.
- `dec_lives`, in, `NUM_AST`: per-asteroid ship-hit events, one bit per asteroid.
- `start_btn`, in, 1: start button, already debounced, level.
- `move_out`, out, 1: equals `move_in & (state == PLAY)`. Combinational.
- `score_bcd`, out, 16: four BCD digits; [3:0] is the units digit.
- `lives`, out, 3: lives remaining.
- `state`, out, 2: IDLE = 0, PLAY = 1, HIT = 2, OVER = 3.
- `game_over`, out, 1: high while `state == OVER`.

## Operation

- All state updates happen only on cycles where `pixpulse` is high. The asteroid outputs are held for a full pixel period, so each event is sampled exactly once.
- Reset values:
  - `score_bcd` = 0
  - `lives` = 0
  - `state` = IDLE
  - `game_over` = 0
  - start edge register = 0
  - freeze counter = 0
- Start edge: `start_rise = start_btn & ~start_q`. `start_q` updates every `pixpulse`.
- IDLE:
  - Events are ignored.
  - On `start_rise`: `score_bcd` ← 0, `lives` ← `START_LIVES`, go to PLAY.
- PLAY:
  - Let `n_s` = popcount of `inc_score` and `n_d` = popcount of `dec_lives`, each 3 bits.
  - Score: add `n_s` to `score_bcd` using per-digit BCD addition with ripple carry (a digit greater than 9 gets +6 and carries).
  - Score saturation: if the result would exceed 9999, hold at 9999.
  - Lives: `lives` ← `lives` − `n_d`, saturating at 0.
  - If `n_d` > 0 and the new `lives` = 0, go to OVER.
  - Else if `n_d` > 0, load freeze counter ← `HIT_FRAMES` and go to HIT.
  - Score and lives both update in the same cycle. A score event coincident with the final hit still counts.
- HIT:
  - `move_out` is forced low.
  - `inc_score` and `dec_lives` are ignored.
  - Each `frame` decrements the freeze counter. When it reaches 0, return to PLAY.
- OVER:
  - `score_bcd` and `lives` are held.
  - On `start_rise`: clear the score, reload lives, go to PLAY.
- `start_rise` in PLAY or HIT has no effect.
- Reset asserted at any point, including mid-HIT, returns everything to the reset values on the next edge. No pending event survives reset.

## Timing

- Registered outputs update on the same `clk` edge on which `pixpulse` is sampled high. Event to `score_bcd`/`lives`/`state` latency is 1 cycle.
- `move_out` has zero latency: it is a combinational AND of `move_in` with the registered state.
- HIT duration is exactly `HIT_FRAMES` `frame` pulses, counted from the first `frame` after entry.
- A `frame` pulse coincident with the transition into HIT is not counted.
- The freeze counter is 8 bits. Arithmetic is unsigned.

## Test plan

1. Reset release: all outputs at their reset values, `state` = 0. Pulse `start_btn` -> `state` = 1, `lives` = 3, `score_bcd` = 0x0000.
2. Multi-event scoring: in PLAY, `inc_score` = 4'b1011 for one pixel period starting from score 0x0008 -> `score_bcd` = 0x0011. Holding the pulse over 4 clocks must not add 3 four times.
3. Saturation: preload the score to 0x9998, then `inc_score` = 4'b0111 -> 0x9999. A further event leaves it at 0x9999.
4. Hit and freeze: `HIT_FRAMES` = 2, `dec_lives` = 4'b0001 -> `lives` = 2 and `state` = 2. `move_out` is low while `move_in` toggles. Exactly 2 `frame` pulses -> `state` = 1.
5. Game over: with `lives` = 1, `dec_lives` = 4'b0110 and `inc_score` = 4'b0001 in the same cycle -> `lives` = 0, `state` = 3, `game_over` = 1, score +1. Then `start_btn` -> `state` = 1, `lives` = 3, score 0.
6. Reset mid-HIT: assert `rst` low during HIT -> all outputs at reset values asynchronously. After release, `state` = 0 and events are ignored.

Source files
------------

// File: rtl/score_lives.sv
// Game bookkeeping: collects asteroid score/hit pulses, keeps a saturating BCD
// score and a lives count, and sequences IDLE/PLAY/HIT/OVER. Motion is gated to PLAY.
module score_lives #(
  parameter int NUM_AST     = 4,
  parameter int START_LIVES = 3,
  parameter int HIT_FRAMES  = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixpulse,
  input  logic               frame,
  input  logic               move_in,
  input  logic [NUM_AST-1:0] inc_score,
  input  logic [NUM_AST-1:0] dec_lives,
  input  logic               start_btn,
  output logic               move_out,
  output logic [15:0]        score_bcd,
  output logic [2:0]         lives,
  output logic [1:0]         state,
  output logic               game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  freeze_q, freeze_d;
  logic        start_q;
  logic        start_rise;

  logic [2:0]  n_s, n_d;
  logic [15:0] sum_bcd;
  logic [2:0]  lives_sub;

  assign start_rise = start_btn & ~start_q;

  always_comb begin
    n_s = '0;
    n_d = '0;
    for (int i = 0; i < NUM_AST; i++) begin
      n_s = n_s + 3'(inc_score[i]);
      n_d = n_d + 3'(dec_lives[i]);
    end
  end

  // Digit-serial BCD add; a carry out of the thousands digit means > 9999.
  always_comb begin
    logic [4:0] dsum;
    logic       carry;
    sum_bcd = '0;
    carry   = 1'b0;
    dsum    = '0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, score_q[4*i +: 4]} + {4'b0, carry};
      if (i == 0) dsum = dsum + {2'b0, n_s};
      if (dsum > 5'd9) begin
        sum_bcd[4*i +: 4] = 4'(dsum + 5'd6);
        carry             = 1'b1;
      end else begin
        sum_bcd[4*i +: 4] = dsum[3:0];
        carry             = 1'b0;
      end
    end
    if (carry) sum_bcd = 16'h9999;
  end

  assign lives_sub = (n_d >= lives_q) ? 3'd0 : lives_q - n_d;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    freeze_d = freeze_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          score_d = '0;
          lives_d = 3'(START_LIVES);
          state_d = PLAY;
        end
      end
      PLAY: begin
        score_d = sum_bcd;
        lives_d = lives_sub;
        if (n_d != 3'd0) begin
          if (lives_sub == 3'd0) begin
            state_d = OVER;
          end else begin
            freeze_d = 8'(HIT_FRAMES);
            state_d  = HIT;
          end
        end
      end
      HIT: begin
        if (frame) begin
          if (freeze_q <= 8'd1) begin
            freeze_d = '0;
            state_d  = PLAY;
          end else begin
            freeze_d = freeze_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      score_q  <= '0;
      lives_q  <= '0;
      freeze_q <= '0;
      start_q  <= 1'b0;
    end else if (pixpulse) begin
      state_q  <= state_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      freeze_q <= freeze_d;
      start_q  <= start_btn;
    end
  end

  assign move_out  = move_in & (state_q == PLAY);
  assign score_bcd = score_q;
  assign lives     = lives_q;
  assign state     = state_q;
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_score_lives.sv
// Bench for score_lives: directed game scenarios followed by random play, all
// checked against an integer-valued game model.
module tb_score_lives;

  localparam int NUM_AST     = 4;
  localparam int START_LIVES = 3;
  localparam int HIT_FRAMES  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               pixpulse, frame, move_in, start_btn;
  logic [NUM_AST-1:0] inc_score, dec_lives;
  logic               move_out, game_over;
  logic [15:0]        score_bcd;
  logic [2:0]         lives;
  logic [1:0]         state;

  score_lives #(
    .NUM_AST    (NUM_AST),
    .START_LIVES(START_LIVES),
    .HIT_FRAMES (HIT_FRAMES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pixpulse (pixpulse),
    .frame    (frame),
    .move_in  (move_in),
    .inc_score(inc_score),
    .dec_lives(dec_lives),
    .start_btn(start_btn),
    .move_out (move_out),
    .score_bcd(score_bcd),
    .lives    (lives),
    .state    (state),
    .game_over(game_over)
  );

  // reference model: plain integers, state numbered as on the state port
  int   m_score, m_lives, m_state, m_freeze;
  bit   m_start_q;
  logic [20:0] exp_q[$];
  int   vec_count = 0;
  int   err_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] model_pack();
    logic [1:0] s;
    logic [2:0] l;
    s = 2'(m_state);
    l = 3'(m_lives);
    return {s, l, to_bcd(m_score)};
  endfunction

  task automatic model_reset();
    m_score   = 0;
    m_lives   = 0;
    m_state   = 0;
    m_freeze  = 0;
    m_start_q = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] inc, input logic [3:0] dec, input logic st,
                            input logic frm);
    bit rise;
    int ns, nd;
    rise      = st && !m_start_q;
    m_start_q = st;
    ns        = $countones(inc);
    nd        = $countones(dec);
    case (m_state)
      0, 3: if (rise) begin
        m_score = 0;
        m_lives = START_LIVES;
        m_state = 1;
      end
      1: begin
        m_score = (m_score + ns > 9999) ? 9999 : m_score + ns;
        m_lives = (nd >= m_lives) ? 0 : m_lives - nd;
        if (nd > 0) begin
          if (m_lives == 0) m_state = 3;
          else begin
            m_freeze = HIT_FRAMES;
            m_state  = 2;
          end
        end
      end
      default: if (frm) begin
        m_freeze = m_freeze - 1;
        if (m_freeze == 0) m_state = 1;
      end
    endcase
    exp_q.push_back(model_pack());
  endtask

  task automatic check_all(input string tag);
    check({tag, "_score"}, 32'(score_bcd), 32'(to_bcd(m_score)));
    check({tag, "_lives"}, 32'(lives), 32'(m_lives));
    check({tag, "_state"}, 32'(state), 32'(m_state));
    check({tag, "_over"}, 32'(game_over), 32'(m_state == 3));
  endtask

  // One pixel period: inputs held 4 clocks, pixpulse on the last.
  task automatic pix_period(input logic [3:0] inc, input logic [3:0] dec, input logic st,
                            input logic frm);
    logic [20:0] exp;
    inc_score = inc;
    dec_lives = dec;
    start_btn = st;
    for (int c = 0; c < 4; c++) begin
      pixpulse = (c == 3);
      frame    = (c == 3) ? frm : 1'b0;
      move_in  = 1'($urandom_range(0, 1));
      #1;
      check("move_out", 32'(move_out), 32'(move_in && (m_state == 1)));
      @(posedge clk);
      if (c == 3) model_step(inc, dec, st, frm);
      #1;
      if (c == 3) begin
        exp = exp_q.pop_front();
        check("sb", 32'({state, lives, score_bcd}), 32'(exp));
        check("game_over", 32'(game_over), 32'(m_state == 3));
      end else begin
        check("hold", 32'({state, lives, score_bcd}), 32'(model_pack()));
      end
    end
    pixpulse = 1'b0;
    frame    = 1'b0;
  endtask

  initial begin
    logic [3:0] inc, dec;
    logic       st;
    int         gap;

    rst = 1'b0;
    pixpulse = 1'b0; frame = 1'b0; move_in = 1'b0; start_btn = 1'b0;
    inc_score = '0; dec_lives = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // start game
    pix_period(4'h0, 4'h0, 1'b1, 1'b0);
    check("start_state", 32'(state), 32'd1);
    check("start_lives", 32'(lives), 32'd3);
    check("start_score", 32'(score_bcd), 32'h0);
    pix_period(4'h0, 4'h0, 1'b0, 1'b0);

    // multi-event scoring from 0008
    pix_period(4'hf, 4'h0, 1'b0, 1'b0);
    pix_period(4'hf, 4'h0, 1'b0, 1'b0);
    check("score8", 32'(score_bcd), 32'h0008);
    pix_period(4'b1011, 4'h0, 1'b0, 1'b0);
    check("score11", 32'(score_bcd), 32'h0011);

    // hit with frame pulse coincident with entry (not counted), then freeze
    pix_period(4'h0, 4'b0001, 1'b0, 1'b1);
    check("hit_lives", 32'(lives), 32'd2);
    check("hit_state", 32'(state), 32'd2);
    pix_period(4'hf, 4'hf, 1'b1, 1'b0);
    pix_period(4'h0, 4'h0, 1'b0, 1'b1);
    check("freeze1", 32'(state), 32'd2);
    pix_period(4'h0, 4'h0, 1'b0, 1'b1);
    check("freeze_done", 32'(state), 32'd1);
    check("freeze_lives", 32'(lives), 32'd2);

    // second hit down to one life
    pix_period(4'h0, 4'b0001, 1'b0, 1'b0);
    pix_period(4'h0, 4'h0, 1'b0, 1'b1);
    pix_period(4'h0, 4'h0, 1'b0, 1'b1);
    check("one_life", 32'(lives), 32'd1);

    // final hit with coincident score
    pix_period(4'b0001, 4'b0110, 1'b0, 1'b0);
    check("over_lives", 32'(lives), 32'd0);
    check("over_state", 32'(state), 32'd3);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_score", 32'(score_bcd), 32'h0012);
    pix_period(4'hf, 4'hf, 1'b0, 1'b1);
    pix_period(4'h0, 4'h0, 1'b1, 1'b0);
    check("restart_state", 32'(state), 32'd1);
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_score", 32'(score_bcd), 32'h0);
    pix_period(4'h0, 4'h0, 1'b0, 1'b0);

    // saturation
    while (m_score < 9998) begin
      gap = 9998 - m_score;
      inc = (gap >= 4) ? 4'hf : (gap == 3) ? 4'h7 : (gap == 2) ? 4'h3 : 4'h1;
      pix_period(inc, 4'h0, 1'b0, 1'b0);
    end
    check("score9998", 32'(score_bcd), 32'h9998);
    pix_period(4'b0111, 4'h0, 1'b0, 1'b0);
    check("sat1", 32'(score_bcd), 32'h9999);
    pix_period(4'b0001, 4'h0, 1'b0, 1'b0);
    check("sat2", 32'(score_bcd), 32'h9999);

    // reset mid-HIT
    pix_period(4'h0, 4'b0001, 1'b0, 1'b0);
    check("pre_rst_hit", 32'(state), 32'd2);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    pix_period(4'hf, 4'hf, 1'b0, 1'b1);
    check("idle_ignore_state", 32'(state), 32'd0);
    check("idle_ignore_score", 32'(score_bcd), 32'h0);

    // random play
    st = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) st = ~st;
      inc = 4'($urandom_range(0, 15));
      dec = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      pix_period(inc, dec, st, 1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
